// File: rtl/uart_frame_rx_if.sv
// Byte-in / frame-out handshake bundle for the UART frame parser.
interface uart_frame_rx_if #(
  parameter int FULL_DATA_SIZE = 40,
  parameter int BYTE_SIZE      = 8
);
  logic [BYTE_SIZE-1:0]      in_byte;
  logic                      in_valid;
  logic                      in_ready;
  logic [FULL_DATA_SIZE-1:0] full_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      crc_err;
  logic                      len_err;
  logic                      timeout_err;

  // Byte source / frame sink side.
  modport master (
    output in_byte, in_valid, out_ready,
    input  in_ready, full_data, out_valid, crc_err, len_err, timeout_err
  );

  // Parser side.
  modport slave (
    input  in_byte, in_valid, out_ready,
    output in_ready, full_data, out_valid, crc_err, len_err, timeout_err
  );
endinterface

// File: rtl/uart_frame_rx.sv
// UART frame parser: hunts sync, captures {opt, len, data}, checks CRC-32
// (poly 04C11DB7, init all-ones, MSB-first, no reflection, no final XOR)
// and presents the frame on a valid/ready output.
module uart_frame_rx #(
  parameter int                   FULL_DATA_SIZE = 40,
  parameter int                   BYTE_SIZE      = 8,
  parameter int                   TIMEOUT_CYCLES = 1024,
  parameter logic [BYTE_SIZE-1:0] SYNC_BYTE      = 8'hFE
) (
  input logic            CLK,
  input logic            RST,
  uart_frame_rx_if.slave bus
);

  localparam int DATA_BYTES = (FULL_DATA_SIZE - 2*BYTE_SIZE) / BYTE_SIZE;
  localparam int IDLE_W     = $clog2(TIMEOUT_CYCLES);
  localparam int RXC_W      = 32 - BYTE_SIZE;
  localparam int OPT_MSB    = FULL_DATA_SIZE - 1;
  localparam int LEN_MSB    = FULL_DATA_SIZE - 1 - BYTE_SIZE;
  localparam int DAT_MSB    = FULL_DATA_SIZE - 1 - 2*BYTE_SIZE;

  localparam logic [31:0]          CRC_POLY     = 32'h04C11DB7;
  localparam logic [31:0]          CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [BYTE_SIZE-1:0] DATA_BYTES_B = BYTE_SIZE'(DATA_BYTES);
  localparam logic [IDLE_W-1:0]    IDLE_LAST    = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_SYNC, ST_OPT, ST_LEN, ST_DATA, ST_CSM, ST_OUT
  } state_t;

  state_t                    state_q, state_d;
  logic [31:0]               crc_q;
  logic [FULL_DATA_SIZE-1:0] full_q;
  logic [BYTE_SIZE-1:0]      byte_cnt_q;
  logic [1:0]                csm_cnt_q;
  logic [RXC_W-1:0]          rx_crc_q;
  logic [IDLE_W-1:0]         idle_q;
  logic                      crc_err_q, len_err_q, tmo_err_q;
  logic                      crc_err_d, len_err_d, tmo_err_d;
  logic                      acc, active, idle_hit;
  logic [BYTE_SIZE-1:0]      len_q;
  logic [31:0]               crc_upd;

  // One byte of MSB-first CRC-32, bit-serial unrolled.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c,
                                             input logic [BYTE_SIZE-1:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = BYTE_SIZE-1; i >= 0; i--) begin
      fb = r[31] ^ b[i];
      r  = {r[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

  assign acc      = bus.in_valid && bus.in_ready;
  assign active   = (state_q == ST_OPT) || (state_q == ST_LEN) ||
                    (state_q == ST_DATA) || (state_q == ST_CSM);
  assign idle_hit = (idle_q == IDLE_LAST);
  assign len_q    = full_q[LEN_MSB -: BYTE_SIZE];
  assign crc_upd  = crc32_byte(crc_q, bus.in_byte);

  assign bus.in_ready    = (state_q != ST_OUT);
  assign bus.out_valid   = (state_q == ST_OUT);
  assign bus.full_data   = full_q;
  assign bus.crc_err     = crc_err_q;
  assign bus.len_err     = len_err_q;
  assign bus.timeout_err = tmo_err_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_SYNC;
    else     state_q <= state_d;
  end

  // Next state and error strobes; an idle timeout overrides everything.
  always_comb begin
    state_d   = state_q;
    crc_err_d = 1'b0;
    len_err_d = 1'b0;
    tmo_err_d = 1'b0;
    if (active && !acc && idle_hit) begin
      state_d   = ST_SYNC;
      tmo_err_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_SYNC: if (acc && bus.in_byte == SYNC_BYTE) state_d = ST_OPT;
        ST_OPT:  if (acc) state_d = ST_LEN;
        ST_LEN: begin
          if (acc) begin
            if (bus.in_byte == '0)                state_d = ST_CSM;
            else if (bus.in_byte <= DATA_BYTES_B) state_d = ST_DATA;
            else begin
              state_d   = ST_SYNC;
              len_err_d = 1'b1;
            end
          end
        end
        ST_DATA: if (acc && byte_cnt_q == len_q - 1'b1) state_d = ST_CSM;
        ST_CSM: begin
          if (acc && csm_cnt_q == 2'd3) begin
            if ({rx_crc_q, bus.in_byte} == crc_q) state_d = ST_OUT;
            else begin
              state_d   = ST_SYNC;
              crc_err_d = 1'b1;
            end
          end
        end
        ST_OUT:  if (bus.out_ready) state_d = ST_SYNC;
        default: state_d = ST_SYNC;
      endcase
    end
  end

  // Field capture and running CRC; nothing is written while a frame is held.
  always_ff @(posedge CLK) begin
    if (RST) begin
      crc_q      <= CRC_INIT;
      full_q     <= '0;
      byte_cnt_q <= '0;
      csm_cnt_q  <= '0;
      rx_crc_q   <= '0;
    end else if (acc) begin
      unique case (state_q)
        ST_SYNC: begin
          if (bus.in_byte == SYNC_BYTE) begin
            crc_q      <= CRC_INIT;
            full_q     <= '0;
            byte_cnt_q <= '0;
            csm_cnt_q  <= '0;
          end
        end
        ST_OPT: begin
          full_q[OPT_MSB -: BYTE_SIZE] <= bus.in_byte;
          crc_q                        <= crc_upd;
        end
        ST_LEN: begin
          full_q[LEN_MSB -: BYTE_SIZE] <= bus.in_byte;
          crc_q                        <= crc_upd;
        end
        ST_DATA: begin
          // Slot 0 sits in the most significant byte of the data field.
          for (int k = 0; k < DATA_BYTES; k++)
            if (byte_cnt_q == k[BYTE_SIZE-1:0])
              full_q[DAT_MSB - k*BYTE_SIZE -: BYTE_SIZE] <= bus.in_byte;
          crc_q      <= crc_upd;
          byte_cnt_q <= (byte_cnt_q == len_q - 1'b1) ? '0 : byte_cnt_q + 1'b1;
        end
        ST_CSM: begin
          rx_crc_q  <= {rx_crc_q[RXC_W-BYTE_SIZE-1:0], bus.in_byte};
          csm_cnt_q <= csm_cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Inter-byte idle counter: restarts on every byte and every state change.
  always_ff @(posedge CLK) begin
    if (RST)                                   idle_q <= '0;
    else if (!active || acc || state_d != state_q) idle_q <= '0;
    else                                       idle_q <= idle_q + 1'b1;
  end

  // Single-cycle error pulses, registered one cycle after the cause.
  always_ff @(posedge CLK) begin
    if (RST) begin
      crc_err_q <= 1'b0;
      len_err_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      crc_err_q <= crc_err_d;
      len_err_q <= len_err_d;
      tmo_err_q <= tmo_err_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: directed plan plus random frames.
module tb_uart_frame_rx;
  localparam int          FDS  = 40;
  localparam int          BS   = 8;
  localparam logic [7:0]  SYNC = 8'hFE;
  localparam int K_FRAME = 0, K_CRC = 1, K_LEN = 2, K_TMO = 3;

  typedef struct {
    int          kind;
    logic [39:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_rx_if #(.FULL_DATA_SIZE(FDS), .BYTE_SIZE(BS)) bus();

  uart_frame_rx #(
    .FULL_DATA_SIZE(FDS), .BYTE_SIZE(BS), .TIMEOUT_CYCLES(1024), .SYNC_BYTE(SYNC)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   rand_ready = 1'b0;
  bit   force_ready = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference CRC: message bits fed MSB-first through a 33-bit divisor.
  function automatic logic [31:0] crc_ref(input logic [7:0] m[$]);
    logic [32:0] r;
    r = {1'b0, 32'hFFFFFFFF};
    foreach (m[i])
      for (int b = 7; b >= 0; b--) begin
        r = {r[31:0], 1'b0} ^ {32'h0, 1'b0};
        if (r[32] ^ m[i][b]) r = r ^ 33'h104C11DB7;
        r[32] = 1'b0;
      end
    return r[31:0];
  endfunction

  function automatic logic [39:0] frame_val(input logic [7:0] opt, input logic [7:0] len,
                                            input logic [23:0] dpk);
    logic [23:0] mask;
    mask = ~(24'hFFFFFF >> (8 * int'(len)));
    return {opt, len, dpk & mask};
  endfunction

  task automatic push_exp(input int k, input logic [39:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one byte and hold it until the parser takes it.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!bus.in_ready) check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic gap(input bit en);
    if (en) idle($urandom_range(0, 2));
  endtask

  task automatic send_frame(input logic [7:0] opt, input logic [7:0] len,
                            input logic [23:0] dpk, input logic [31:0] cx, input bit gaps);
    logic [7:0]  body[$];
    logic [31:0] c;
    send_byte(SYNC); gap(gaps);
    send_byte(opt);  gap(gaps);
    if (len > 8'd3) begin
      push_exp(K_LEN, 40'h0);
      send_byte(len);
      check("len_err_latency", 64'(bus.len_err), 64'd1);
      return;
    end
    send_byte(len); gap(gaps);
    body.push_back(opt);
    body.push_back(len);
    for (int i = 0; i < int'(len); i++) begin
      body.push_back(dpk[23-8*i -: 8]);
      send_byte(dpk[23-8*i -: 8]); gap(gaps);
    end
    c = crc_ref(body) ^ cx;
    for (int j = 0; j < 4; j++) begin
      if (j == 3) push_exp(cx == 0 ? K_FRAME : K_CRC, frame_val(opt, len, dpk));
      send_byte(c[31-8*j -: 8]);
      if (j < 3) gap(gaps);
    end
    if (cx == 0) check("out_valid_latency", 64'(bus.out_valid), 64'd1);
    else         check("crc_err_latency", 64'(bus.crc_err), 64'd1);
  endtask

  task automatic pop_cmp(input int k, input logic [39:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", 64'(k), 64'd99);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 64'(k), 64'(e.kind));
    if (k == K_FRAME) check("frame_data", 64'(d), 64'(e.data));
  endtask

  // Output monitor: pops the scoreboard on every frame handshake or error pulse.
  task automatic monitor();
    logic        hold = 1'b0;
    logic [39:0] held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin hold = 1'b0; continue; end
      if (hold && bus.out_valid) check("held_full_data", 64'(bus.full_data), 64'(held));
      if (bus.out_valid) check("in_ready_low_in_out", 64'(bus.in_ready), 64'd0);
      if (bus.crc_err || bus.len_err || bus.timeout_err)
        check("single_event", 64'($countones({bus.crc_err, bus.len_err, bus.timeout_err, bus.out_valid})), 64'd1);
      if (bus.out_valid && bus.out_ready) pop_cmp(K_FRAME, bus.full_data);
      if (bus.crc_err)     pop_cmp(K_CRC, 40'h0);
      if (bus.len_err)     pop_cmp(K_LEN, 40'h0);
      if (bus.timeout_err) pop_cmp(K_TMO, 40'h0);
      hold = bus.out_valid && !bus.out_ready;
      held = bus.full_data;
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk); #2;
      bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_full_data"}, 64'(bus.full_data), 64'd0);
    check({tag, "_errs"}, 64'({bus.crc_err, bus.len_err, bus.timeout_err}), 64'd0);
  endtask

  initial begin
    int  n;
    bit  found;
    logic [7:0]  len, g;
    logic [31:0] cx;
    bus.in_byte   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    fork
      monitor();
      ready_driver();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // 1: basic 3-byte frame
    send_frame(8'h01, 8'h03, 24'hAABBCC, 32'h0, 1'b0);
    idle(2);
    // 2: leading garbage, 1-byte frame
    send_byte(8'h00); send_byte(8'h55); send_byte(8'hFF);
    send_frame(8'h02, 8'h01, 24'h7E0000, 32'h0, 1'b0);
    idle(2);
    // 3: corrupted CRC then recovery
    send_frame(8'h01, 8'h03, 24'hAABBCC, 32'h1, 1'b0);
    check("crc_err_one_cycle_pre", 64'(bus.out_valid), 64'd0);
    idle(1);
    check("crc_err_one_cycle", 64'(bus.crc_err), 64'd0);
    send_frame(8'h01, 8'h03, 24'hAABBCC, 32'h0, 1'b0);
    idle(2);
    // 4: oversize len, then hunting resumes
    send_frame(8'h05, 8'h04, 24'h0, 32'h0, 1'b0);
    send_byte(8'h01); send_byte(8'h02);
    send_frame(8'h11, 8'h02, 24'hFEFE00, 32'h0, 1'b1);
    idle(2);
    // 5: inter-byte timeout, then zero-length frame
    send_byte(SYNC);
    push_exp(K_TMO, 40'h0);
    send_byte(8'h01);
    n = 0; found = 1'b0;
    while (!found && n < 1100) begin
      @(posedge clk); #1; n++;
      if (bus.timeout_err) found = 1'b1;
    end
    check("timeout_cycles", 64'(n), 64'd1024);
    idle(1);
    check("timeout_one_cycle", 64'(bus.timeout_err), 64'd0);
    send_frame(8'h09, 8'h00, 24'h0, 32'h0, 1'b0);
    idle(2);
    // 6: back-pressure hold, then mid-frame reset
    force_ready = 1'b0;
    idle(1);
    send_frame(8'h3C, 8'h02, 24'h1234FF, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready",  64'(bus.in_ready), 64'd0);
      check("bp_full_data", 64'(bus.full_data), 64'h3C02123400);
    end
    force_ready = 1'b1;
    idle(1);
    check("after_handshake_out_valid", 64'(bus.out_valid), 64'd0);
    check("after_handshake_in_ready",  64'(bus.in_ready), 64'd1);
    send_byte(SYNC); send_byte(8'h01); send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'hBB);
    rst = 1'b1;
    idle(1);
    check_reset_outputs("midframe_reset");
    rst = 1'b0;
    send_frame(8'h01, 8'h03, 24'hAABBCC, 32'h0, 1'b1);

    // Random frames with random back-pressure, gaps, garbage and corruption.
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom);
        send_byte(g == SYNC ? 8'h00 : g);
      end
      len = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(4, 255));
      cx  = ($urandom_range(0, 5) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      send_frame(8'($urandom), len, 24'($urandom), cx, 1'b1);
    end
    rand_ready  = 1'b0;
    force_ready = 1'b1;

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin idle(1); n++; end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
